// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding and the
// round-robin search used by the priority picker.
package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StHeader  = 2'd1,
      StPayload = 2'd2
   } arb_state_e;

   localparam int MaxCh = 8;

   // First set bit of req at or after (last + 1) mod num_ch, wrapping around.
   // Returns last when req is empty.
   function automatic int rr_search(input logic [MaxCh-1:0] req, input int last,
                                    input int num_ch);
      int win;
      int idx;
      win = last;
      // Walk downward so the lowest offset from last is the one that sticks.
      for (int k = MaxCh; k >= 1; k--) begin
         if (k <= num_ch) begin
            idx = last + k;
            if (idx >= num_ch) begin
               idx = idx - num_ch;
            end
            if (req[idx[2:0]]) begin
               win = idx;
            end
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest-offset requester after the last winner.
module rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDW    = 2
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [IDW-1:0]    i_last,
   output logic [IDW-1:0]    o_winner,
   output logic              o_any
);

   logic [MaxCh-1:0] w_req;

   always_comb begin
      w_req               = '0;
      w_req[NUM_CH-1:0]   = i_req;
   end

   assign o_winner = IDW'(rr_search(w_req, int'(i_last), NUM_CH));
   assign o_any    = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging NUM_CH AXI-stream byte sources onto one UART transmit stream,
// with optional per-burst channel header and a bounded burst length.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int         NUM_CH      = 4,
   parameter bit         HEADER_EN   = 1'b1,
   parameter logic [7:0] HEADER_BASE = 8'hA0,
   parameter int         MAX_BURST   = 64
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [NUM_CH*8-1:0]        s_tdata,
   input  logic [NUM_CH-1:0]          s_tvalid,
   input  logic [NUM_CH-1:0]          s_tlast,
   output logic [NUM_CH-1:0]          s_tready,
   output logic [7:0]                 m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [$clog2(NUM_CH)-1:0]  grant_id,
   output logic                       busy
);

   localparam int         IDW       = $clog2(NUM_CH);
   localparam logic [7:0] MaxBurstB = 8'(MAX_BURST);

   arb_state_e        r_state, w_state_nxt;
   logic [IDW-1:0]    r_grant, w_grant_nxt;
   logic [IDW-1:0]    r_last, w_last_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [IDW-1:0]    w_win;
   logic              w_any;
   logic [7:0]        w_sel_data;
   logic              w_sel_valid;
   logic              w_sel_last;
   logic [NUM_CH-1:0] w_sel_oh;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .IDW    (IDW)
   ) u_rr_pick (
      .i_req    (s_tvalid),
      .i_last   (r_last),
      .o_winner (w_win),
      .o_any    (w_any)
   );

   // Select the granted channel's sideband; one-hot also steers s_tready.
   always_comb begin
      w_sel_data  = 8'h00;
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_oh    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_grant == IDW'(i)) begin
            w_sel_data  = s_tdata[i*8 +: 8];
            w_sel_valid = s_tvalid[i];
            w_sel_last  = s_tlast[i];
            w_sel_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      w_cnt_inc   = r_cnt + 8'd1;
      m_tvalid    = 1'b0;
      m_tdata     = 8'h00;
      s_tready    = '0;
      unique case (r_state)
         StIdle: begin
            if (w_any) begin
               w_grant_nxt = w_win;
               w_last_nxt  = w_win;
               w_cnt_nxt   = 8'd0;
               w_state_nxt = HEADER_EN ? StHeader : StPayload;
            end
         end
         StHeader: begin
            m_tvalid = 1'b1;
            m_tdata  = HEADER_BASE | 8'(r_grant);
            if (m_tready) begin
               w_state_nxt = StPayload;
            end
         end
         StPayload: begin
            m_tvalid = w_sel_valid;
            m_tdata  = w_sel_data;
            s_tready = w_sel_oh & {NUM_CH{m_tready}};
            if (w_sel_valid && m_tready) begin
               w_cnt_nxt = w_cnt_inc;
               // End of packet and burst-limit release collapse into one exit.
               if (w_sel_last || (w_cnt_inc == MaxBurstB)) begin
                  w_state_nxt = StIdle;
               end
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= StIdle;
         r_grant <= '0;
         r_last  <= IDW'(NUM_CH - 1);
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign grant_id = r_grant;
   assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packets checked against a
// transaction-level round-robin model of the expected output byte stream.
module tb_uart_tx_arbiter;

   localparam int         NCH = 4;
   localparam int         MB  = 4;
   localparam logic [7:0] HDR = 8'hA0;

   typedef struct {
      logic [7:0] data;
      int         ch;
      bit         hdr;
   } item_t;

   logic             aclk = 1'b0;
   logic             aresetn;
   logic [NCH*8-1:0] s_tdata;
   logic [NCH-1:0]   s_tvalid, s_tlast, s_tready;
   logic [7:0]       m_tdata;
   logic             m_tvalid, m_tready;
   logic [1:0]       grant_id;
   logic             busy;

   logic [15:0]      b_s_tdata;
   logic [1:0]       b_s_tvalid, b_s_tlast, b_s_tready;
   logic [7:0]       b_m_tdata;
   logic             b_m_tvalid, b_m_tready;
   logic             b_grant_id;
   logic             b_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] src_d   [NCH][64];
   bit         src_l   [NCH][64];
   int         src_len [NCH];
   int         src_rd  [NCH];
   int         model_last;
   item_t      exp_q[$];

   always #5 aclk = ~aclk;

   uart_tx_arbiter #(
      .NUM_CH      (NCH),
      .HEADER_EN   (1'b1),
      .HEADER_BASE (HDR),
      .MAX_BURST   (MB)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .grant_id (grant_id),
      .busy     (busy)
   );

   uart_tx_arbiter #(
      .NUM_CH      (2),
      .HEADER_EN   (1'b0),
      .HEADER_BASE (HDR),
      .MAX_BURST   (64)
   ) dut_nohdr (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_tdata  (b_s_tdata),
      .s_tvalid (b_s_tvalid),
      .s_tlast  (b_s_tlast),
      .s_tready (b_s_tready),
      .m_tdata  (b_m_tdata),
      .m_tvalid (b_m_tvalid),
      .m_tready (b_m_tready),
      .grant_id (b_grant_id),
      .busy     (b_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_src();
      for (int c = 0; c < NCH; c++) begin
         src_len[c] = 0;
         src_rd[c]  = 0;
      end
   endtask

   // step == 0 selects random payload bytes.
   task automatic load_pkt(input int ch, input int len, input logic [7:0] first,
                           input logic [7:0] step);
      for (int i = 0; i < len; i++) begin
         src_d[ch][src_len[ch]] = (step == 8'h00) ? 8'($urandom_range(255))
                                                   : 8'(first + 8'(i) * step);
         src_l[ch][src_len[ch]] = (i == len - 1);
         src_len[ch]++;
      end
   endtask

   // Expected stream: every pending channel is valid whenever the arbiter is idle, so bursts
   // follow plain round-robin over channels with remaining data, capped at MB bytes each.
   function automatic void build_model();
      int  rd [NCH];
      int  last, found, n, c;
      bit  done;
      for (int i = 0; i < NCH; i++) rd[i] = src_rd[i];
      last = model_last;
      exp_q.delete();
      while (1) begin
         found = -1;
         for (int k = 1; k <= NCH; k++) begin
            c = (last + k) % NCH;
            if (found < 0 && rd[c] < src_len[c]) found = c;
         end
         if (found < 0) break;
         last = found;
         exp_q.push_back('{data: HDR | 8'(found), ch: found, hdr: 1'b1});
         n    = 0;
         done = 1'b0;
         while (!done) begin
            exp_q.push_back('{data: src_d[found][rd[found]], ch: found, hdr: 1'b0});
            done = src_l[found][rd[found]] || (n + 1 == MB);
            n++;
            rd[found]++;
         end
      end
      model_last = last;
   endfunction

   task automatic do_reset();
      @(negedge aclk);
      aresetn    = 1'b0;
      s_tvalid   = '0;
      s_tlast    = '0;
      s_tdata    = '0;
      m_tready   = 1'b0;
      b_s_tvalid = '0;
      b_s_tlast  = '0;
      b_s_tdata  = '0;
      b_m_tready = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      #1;
      check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_s_tready", 32'(s_tready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m_tdata", 32'(m_tdata), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      aresetn    = 1'b1;
      model_last = NCH - 1;
   endtask

   task automatic run(input bit rnd, input int max_cycles);
      int         cyc  = 0;
      int         post = 0;
      bit         prev_stall = 1'b0;
      logic [7:0] prev_data  = 8'h00;
      bit         pending, gap;
      item_t      h;
      logic [3:0] exp_rdy;
      build_model();
      while (cyc < max_cycles && (exp_q.size() > 0 || post < 2)) begin
         @(negedge aclk);
         for (int c = 0; c < NCH; c++) begin
            pending = (src_rd[c] < src_len[c]);
            gap = rnd && busy && (32'(grant_id) == c) && !prev_stall &&
                  ($urandom_range(3) == 0);
            s_tvalid[c]         = pending && !gap;
            s_tdata[c*8 +: 8]   = pending ? src_d[c][src_rd[c]] : 8'h00;
            s_tlast[c]          = pending && src_l[c][src_rd[c]];
         end
         m_tready = rnd ? 1'($urandom_range(1)) : 1'b1;
         #1;
         if (prev_stall) begin
            check("stall_m_tvalid", 32'(m_tvalid), 32'd1);
            check("stall_m_tdata", 32'(m_tdata), 32'(prev_data));
         end
         if (exp_q.size() == 0) begin
            check("idle_busy", 32'(busy), 32'd0);
            post++;
         end
         if (!busy) begin
            check("idle_m_tvalid", 32'(m_tvalid), 32'd0);
            check("idle_s_tready", 32'(s_tready), 32'd0);
         end else if (exp_q.size() > 0) begin
            h       = exp_q[0];
            exp_rdy = (!h.hdr && m_tready) ? (4'b0001 << h.ch) : 4'b0000;
            check("s_tready", 32'(s_tready), 32'(exp_rdy));
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check("extra_byte", 32'(m_tdata), 32'hFFFF_FFFF);
            end else begin
               h = exp_q.pop_front();
               check("m_tdata", 32'(m_tdata), 32'(h.data));
               check("grant_id", 32'(grant_id), 32'(h.ch));
            end
         end
         for (int c = 0; c < NCH; c++) begin
            if (s_tvalid[c] && s_tready[c]) src_rd[c]++;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         cyc++;
      end
      if (exp_q.size() > 0) check("timeout_left", 32'(exp_q.size()), 32'd0);
      @(negedge aclk);
      s_tvalid = '0;
      s_tlast  = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      do_reset();

      // ch2 sends 11,22,33 with constant ready.
      clear_src();
      load_pkt(2, 3, 8'h11, 8'h11);
      run(1'b0, 50);

      // All channels with 1-byte packets: order 0,1,2,3,0.
      do_reset();
      clear_src();
      load_pkt(0, 1, 8'h30, 8'h01);
      load_pkt(0, 1, 8'h31, 8'h01);
      load_pkt(1, 1, 8'h40, 8'h01);
      load_pkt(2, 1, 8'h50, 8'h01);
      load_pkt(3, 1, 8'h60, 8'h01);
      run(1'b0, 100);

      // Forced release: ch1 6 bytes, ch3 waiting.
      do_reset();
      clear_src();
      load_pkt(1, 6, 8'h01, 8'h01);
      load_pkt(3, 2, 8'hC0, 8'h01);
      run(1'b0, 100);

      // Randomized packets, random ready and in-burst source gaps.
      for (int it = 0; it < 8; it++) begin
         clear_src();
         for (int c = 0; c < NCH; c++) begin
            for (int p = 0; p < int'($urandom_range(2)); p++) begin
               load_pkt(c, int'($urandom_range(9, 1)), 8'h00, 8'h00);
            end
         end
         run(1'b1, 3000);
      end

      // Reset mid-burst on ch2, then ch0 wins against ch2.
      do_reset();
      @(negedge aclk);
      s_tvalid        = 4'b0100;
      s_tdata[23:16]  = 8'h55;
      s_tlast         = 4'b0000;
      m_tready        = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      #1;
      check("midburst_valid", 32'(m_tvalid), 32'd1);
      check("midburst_grant", 32'(grant_id), 32'd2);
      aresetn = 1'b0;
      @(posedge aclk);
      @(negedge aclk);
      #1;
      check("postrst_m_tvalid", 32'(m_tvalid), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
      s_tvalid       = 4'b0101;
      s_tdata[7:0]   = 8'h77;
      aresetn        = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      #1;
      check("postrst_grant", 32'(grant_id), 32'd0);
      check("postrst_hdr", 32'(m_tdata), 32'(HDR));

      // No-header variant: first byte the cycle after the decision.
      do_reset();
      @(negedge aclk);
      b_s_tvalid     = 2'b01;
      b_s_tdata[7:0] = 8'h5A;
      b_s_tlast      = 2'b00;
      b_m_tready     = 1'b1;
      #1;
      check("nohdr_idle_valid", 32'(b_m_tvalid), 32'd0);
      @(posedge aclk);
      @(negedge aclk);
      #1;
      check("nohdr_b0_valid", 32'(b_m_tvalid), 32'd1);
      check("nohdr_b0_data", 32'(b_m_tdata), 32'h5A);
      check("nohdr_b0_ready", 32'(b_s_tready), 32'd1);
      b_s_tdata[7:0] = 8'h6B;
      b_s_tlast      = 2'b01;
      #1;
      check("nohdr_b1_data", 32'(b_m_tdata), 32'h6B);
      @(posedge aclk);
      @(negedge aclk);
      b_s_tvalid = 2'b00;
      #1;
      check("nohdr_done_busy", 32'(b_busy), 32'd0);
      check("nohdr_done_valid", 32'(b_m_tvalid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of AXI-stream requesters (2..8).
REQ-002 Parameter HEADER_EN, default 1, 1 = prefix each granted burst with a channel header byte.
REQ-003 Parameter HEADER_BASE, default 8'hA0, header byte = HEADER_BASE OR channel index.
REQ-004 Parameter MAX_BURST, default 64, maximum payload bytes per grant (1..255).
REQ-005 aclk  input  1  clock; all logic on rising edge.
REQ-006 aresetn  input  1  reset, synchronous, active-low.
REQ-007 s_tdata  input  NUM_CH*8  per-channel byte; channel i at bits [8i+7:8i].
REQ-008 s_tvalid  input  NUM_CH  per-channel valid.
REQ-009 s_tlast  input  NUM_CH  per-channel end of packet.
REQ-010 s_tready  output  NUM_CH  per-channel ready.
REQ-011 m_tdata  output  8  byte to the UART transmitter.
REQ-012 m_tvalid  output  1  valid to the UART transmitter.
REQ-013 m_tready  input  1  ready from the UART transmitter.
REQ-014 grant_id  output  clog2(NUM_CH)  channel currently owning the output; holds its last value in IDLE.
REQ-015 busy  output  1  high when state is not IDLE.

Function
REQ-016 FSM states: IDLE, HEADER, PAYLOAD.
REQ-017 IDLE: if any s_tvalid is high, register the winner into grant_id, clear the burst counter, and go to HEADER if HEADER_EN=1, else to PAYLOAD; otherwise stay in IDLE.
REQ-018 Winner: first channel with s_tvalid high, searching from (last_grant+1) mod NUM_CH upward with wrap-around; last_grant is updated to the winner.
REQ-019 IDLE outputs: m_tvalid=0 and s_tready=0.
REQ-020 HEADER: m_tvalid=1, m_tdata=HEADER_BASE|grant_id, s_tready=0; go to PAYLOAD on m_tvalid&&m_tready.
REQ-021 PAYLOAD: m_tdata=s_tdata[grant_id], m_tvalid=s_tvalid[grant_id], s_tready[grant_id]=m_tready, all other s_tready=0 (combinational pass-through, zero latency).
REQ-022 Each payload handshake increments the 8-bit burst counter.
REQ-023 PAYLOAD exits to IDLE on a handshake with s_tlast[grant_id]=1, or on a handshake that makes the counter equal MAX_BURST (forced release); otherwise it stays in PAYLOAD.
REQ-024 On forced release the remainder of the packet re-arbitrates as a new burst; if HEADER_EN=1 it gets a new header.
REQ-025 A granted channel that drops s_tvalid in PAYLOAD keeps the grant; there is no timeout.
REQ-026 A handshake with both tlast and count==MAX_BURST causes a single release to IDLE.
REQ-027 The minimum gap between bursts is one IDLE cycle; one arbitration decision is made per IDLE cycle.
REQ-028 m_tvalid and m_tdata stay stable while m_tvalid=1 and m_tready=0, as AXI-stream requires.

Reset
REQ-029 While aresetn=0 at a rising edge: state=IDLE, grant_id=0, last_grant=NUM_CH-1, burst counter=0.
REQ-030 Reset outputs: m_tvalid=0, s_tready=all 0, busy=0, m_tdata=0.
REQ-031 Reset mid-burst abandons the burst without emitting further bytes; after reset, channel 0 has first priority.

Structure
REQ-032 A shared package uart_tx_arb_pkg holds the state enum type and the round-robin search function.
REQ-033 The round-robin priority picker is one sub-module, rr_pick (inputs: request vector, last index; outputs: winner index, any-request), and is purely combinational.
REQ-034 The intended downstream is the team's AXI-stream UART transmitter, connected with m_tdata->tdata, m_tvalid->tvalid and m_tready->tready.

Verification
REQ-035 HEADER_EN=1; ch2 sends 3 bytes 11,22,33 (tlast on 33); m_tready=1 -> m_tdata sequence A2,11,22,33; busy low 1 cycle after 33.
REQ-036 All 4 channels valid continuously with 1-byte packets -> grant order 0,1,2,3,0; each burst is header plus 1 byte.
REQ-037 MAX_BURST=4; ch1 sends a 6-byte packet while ch3 waits -> A1 plus 4 bytes, then A3 plus the ch3 packet, then A1 plus the remaining 2 bytes.
REQ-038 m_tready toggles 1,0,0,1 during PAYLOAD -> m_tdata stays stable while stalled; no byte is lost or duplicated; s_tready[grant_id] equals m_tready.
REQ-039 aresetn pulsed low for 1 cycle mid-burst on ch2 -> m_tvalid=0 in the next cycle; next grant goes to ch0 when ch0 and ch2 are both valid.
REQ-040 HEADER_EN=0; ch0 sends a 2-byte packet -> no header; first byte appears on m_tdata the cycle after the IDLE decision.
